// File: rtl/alu_issue_if.sv
// rtl/alu_issue_if.sv - upstream instruction and downstream result handshake bundle for alu_issue
interface alu_issue_if #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [1:0]           in_class;
  logic [2:0]           in_funct3;
  logic                 in_funct7b5;
  logic [XLEN-1:0]      in_pc;
  logic [XLEN-1:0]      in_rs1_data;
  logic [XLEN-1:0]      in_rs2_data;
  logic [XLEN-1:0]      in_imm;
  logic [REG_IDX_W-1:0] in_rs1_idx;
  logic [REG_IDX_W-1:0] in_rs2_idx;
  logic [REG_IDX_W-1:0] in_rd;
  logic                 out_valid;
  logic                 out_ready;
  logic [XLEN-1:0]      out_result;
  logic [REG_IDX_W-1:0] out_rd;
  logic                 out_wr_en;
  logic                 out_branch_taken;
  logic [XLEN-1:0]      out_branch_target;
  logic                 out_illegal;

  modport master (
    output in_valid, in_class, in_funct3, in_funct7b5, in_pc, in_rs1_data, in_rs2_data,
           in_imm, in_rs1_idx, in_rs2_idx, in_rd, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_wr_en, out_branch_taken,
           out_branch_target, out_illegal
  );

  modport slave (
    input  in_valid, in_class, in_funct3, in_funct7b5, in_pc, in_rs1_data, in_rs2_data,
           in_imm, in_rs1_idx, in_rs2_idx, in_rd, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_wr_en, out_branch_taken,
           out_branch_target, out_illegal
  );
endinterface

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - RV32I execute front end: decode, operand select, branch resolve, result register
// Optional operand forwarding from the held result register: define ALU_ISSUE_FWD_EN.
package riscv_32i_defs_pkg;
  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;
endpackage

module alu_issue
  import riscv_32i_defs_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_issue_if.slave      bus,
  output alu_op_t         alu_op,
  output logic [XLEN-1:0] alu_in_a,
  output logic [XLEN-1:0] alu_in_b,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  logic                 out_valid_q, out_valid_d;
  logic [XLEN-1:0]      out_result_q, out_result_d;
  logic [REG_IDX_W-1:0] out_rd_q, out_rd_d;
  logic                 out_wr_en_q, out_wr_en_d;
  logic                 out_branch_taken_q, out_branch_taken_d;
  logic [XLEN-1:0]      out_branch_target_q, out_branch_target_d;
  logic                 out_illegal_q, out_illegal_d;

  alu_op_t         dec_op;
  logic            dec_illegal, is_arith, is_beq, is_bne, sel_pc, sel_imm;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic            accept;

  always_comb begin
    dec_op      = ALU_AND;
    dec_illegal = 1'b1;
    is_arith    = 1'b0;
    is_beq      = 1'b0;
    is_bne      = 1'b0;
    sel_pc      = 1'b0;
    sel_imm     = 1'b0;
    case (bus.in_class)
      2'b00: begin
        is_arith = 1'b1;
        case (bus.in_funct3)
          3'b000:  begin dec_op = bus.in_funct7b5 ? ALU_SUB : ALU_ADD; dec_illegal = 1'b0; end
          3'b111:  begin dec_op = ALU_AND; dec_illegal = 1'b0; end
          3'b110:  begin dec_op = ALU_OR;  dec_illegal = 1'b0; end
          default: ;
        endcase
      end
      2'b01: begin
        is_arith = 1'b1;
        sel_imm  = 1'b1;
        case (bus.in_funct3)
          3'b000:  begin dec_op = ALU_ADD; dec_illegal = 1'b0; end
          3'b111:  begin dec_op = ALU_AND; dec_illegal = 1'b0; end
          3'b110:  begin dec_op = ALU_OR;  dec_illegal = 1'b0; end
          default: ;
        endcase
      end
      2'b10: begin
        dec_op = ALU_SUB;
        case (bus.in_funct3)
          3'b000:  begin is_beq = 1'b1; dec_illegal = 1'b0; end
          3'b001:  begin is_bne = 1'b1; dec_illegal = 1'b0; end
          default: ;
        endcase
      end
      default: begin
        dec_op      = ALU_ADD;
        dec_illegal = 1'b0;
        is_arith    = 1'b1;
        sel_pc      = 1'b1;
        sel_imm     = 1'b1;
      end
    endcase
  end

`ifdef ALU_ISSUE_FWD_EN
  // The held result stays a valid forward source after draining, until the next accept.
  assign rs1_val = (out_wr_en_q && (bus.in_rs1_idx == out_rd_q)) ? out_result_q : bus.in_rs1_data;
  assign rs2_val = (out_wr_en_q && (bus.in_rs2_idx == out_rd_q)) ? out_result_q : bus.in_rs2_data;
`else
  logic unused_fwd_idx;
  assign unused_fwd_idx = ^{bus.in_rs1_idx, bus.in_rs2_idx};
  assign rs1_val = bus.in_rs1_data;
  assign rs2_val = bus.in_rs2_data;
`endif

  always_comb begin
    alu_op   = ALU_AND;
    alu_in_a = '0;
    alu_in_b = '0;
    if (bus.in_valid && !dec_illegal) begin
      alu_op   = dec_op;
      alu_in_a = sel_pc  ? bus.in_pc  : rs1_val;
      alu_in_b = sel_imm ? bus.in_imm : rs2_val;
    end
  end

  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    out_valid_d         = out_valid_q;
    out_result_d        = out_result_q;
    out_rd_d            = out_rd_q;
    out_wr_en_d         = out_wr_en_q;
    out_branch_taken_d  = out_branch_taken_q;
    out_branch_target_d = out_branch_target_q;
    out_illegal_d       = out_illegal_q;
    if (accept) begin
      out_valid_d         = 1'b1;
      out_result_d        = alu_result;
      out_rd_d            = bus.in_rd;
      out_wr_en_d         = is_arith && !dec_illegal && (bus.in_rd != '0);
      out_branch_taken_d  = !dec_illegal && ((is_beq && alu_zero) || (is_bne && !alu_zero));
      out_branch_target_d = bus.in_pc + bus.in_imm;
      out_illegal_d       = dec_illegal;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q         <= 1'b0;
      out_result_q        <= '0;
      out_rd_q            <= '0;
      out_wr_en_q         <= 1'b0;
      out_branch_taken_q  <= 1'b0;
      out_branch_target_q <= '0;
      out_illegal_q       <= 1'b0;
    end else begin
      out_valid_q         <= out_valid_d;
      out_result_q        <= out_result_d;
      out_rd_q            <= out_rd_d;
      out_wr_en_q         <= out_wr_en_d;
      out_branch_taken_q  <= out_branch_taken_d;
      out_branch_target_q <= out_branch_target_d;
      out_illegal_q       <= out_illegal_d;
    end
  end

  assign bus.out_valid         = out_valid_q;
  assign bus.out_result        = out_result_q;
  assign bus.out_rd            = out_rd_q;
  assign bus.out_wr_en         = out_wr_en_q;
  assign bus.out_branch_taken  = out_branch_taken_q;
  assign bus.out_branch_target = out_branch_target_q;
  assign bus.out_illegal       = out_illegal_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - directed self-checking bench for alu_issue with a behavioural ALU
module tb_alu_issue;
  import riscv_32i_defs_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  alu_op_t     alu_op;
  logic [31:0] alu_in_a, alu_in_b, alu_result;
  logic        alu_zero;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] fwd_exp;

  alu_issue_if #(.XLEN(32), .REG_IDX_W(5)) bus ();

  alu_issue #(.XLEN(32), .REG_IDX_W(5)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .alu_op     (alu_op),
    .alu_in_a   (alu_in_a),
    .alu_in_b   (alu_in_b),
    .alu_result (alu_result),
    .alu_zero   (alu_zero)
  );

  always #5 clk = ~clk;

  always_comb begin
    case (alu_op)
      ALU_ADD: alu_result = alu_in_a + alu_in_b;
      ALU_SUB: alu_result = alu_in_a - alu_in_b;
      ALU_AND: alu_result = alu_in_a & alu_in_b;
      ALU_OR:  alu_result = alu_in_a | alu_in_b;
      default: alu_result = 32'h0;
    endcase
  end
  assign alu_zero = (alu_result == 32'h0);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [1:0] cls, input logic [2:0] f3, input logic f7,
                       input logic [31:0] pc, input logic [31:0] rs1, input logic [31:0] rs2,
                       input logic [31:0] imm, input logic [4:0] rd,
                       input logic [4:0] s1, input logic [4:0] s2);
    bus.in_valid    = 1'b1;
    bus.in_class    = cls;
    bus.in_funct3   = f3;
    bus.in_funct7b5 = f7;
    bus.in_pc       = pc;
    bus.in_rs1_data = rs1;
    bus.in_rs2_data = rs2;
    bus.in_imm      = imm;
    bus.in_rd       = rd;
    bus.in_rs1_idx  = s1;
    bus.in_rs2_idx  = s2;
  endtask

  task automatic step_release();
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n         = 1'b0;
    bus.out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_valid", bus.out_valid, 0);
    check("rst_result", bus.out_result, 0);
    check("rst_wr_en", bus.out_wr_en, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("idle_alu_op", alu_op, ALU_AND);
    rst_n = 1'b1;
    @(negedge clk);

    drive(2'b00, 3'b000, 1'b0, 32'h100, 32'h7FFF_FFFF, 32'h1, 32'h0, 5'd5, 0, 0);
    #1 check("add_alu_op", alu_op, ALU_ADD);
    step_release();
    check("add_valid", bus.out_valid, 1);
    check("add_result", bus.out_result, 32'h8000_0000);
    check("add_wr_en", bus.out_wr_en, 1);
    check("add_rd", bus.out_rd, 5);
    check("add_illegal", bus.out_illegal, 0);

    drive(2'b10, 3'b000, 1'b0, 32'hFFFF_FFF0, 32'h1234, 32'h1234, 32'h20, 5'd7, 0, 0);
    #1 check("beq_alu_op", alu_op, ALU_SUB);
    step_release();
    check("beq_taken", bus.out_branch_taken, 1);
    check("beq_target", bus.out_branch_target, 32'h0000_0010);
    check("beq_wr_en", bus.out_wr_en, 0);

    drive(2'b10, 3'b001, 1'b0, 32'hFFFF_FFF0, 32'h1234, 32'h1234, 32'h20, 5'd7, 0, 0);
    step_release();
    check("bne_taken", bus.out_branch_taken, 0);
    check("bne_target", bus.out_branch_target, 32'h0000_0010);

    drive(2'b00, 3'b001, 1'b0, 32'h0, 32'h55, 32'h66, 32'h0, 5'd9, 0, 0);
    #1;
    check("ill_alu_op", alu_op, ALU_AND);
    check("ill_alu_a", alu_in_a, 0);
    check("ill_alu_b", alu_in_b, 0);
    step_release();
    check("ill_flag", bus.out_illegal, 1);
    check("ill_wr_en", bus.out_wr_en, 0);
    check("ill_valid", bus.out_valid, 1);

    drive(2'b01, 3'b000, 1'b1, 32'h0, 32'h10, 32'h999, 32'h5, 5'd0, 0, 0);
    step_release();
    check("addi_x0_result", bus.out_result, 32'h15);
    check("addi_x0_wr_en", bus.out_wr_en, 0);
    check("addi_x0_illegal", bus.out_illegal, 0);

    drive(2'b00, 3'b000, 1'b1, 32'h0, 32'h30, 32'h8, 32'h0, 5'd2, 0, 0);
    step_release();
    check("sub_result", bus.out_result, 32'h28);
    drive(2'b11, 3'b101, 1'b0, 32'h1000, 32'h0, 32'h0, 32'h0002_0000, 5'd8, 0, 0);
    step_release();
    check("auipc_result", bus.out_result, 32'h0002_1000);
    check("auipc_wr_en", bus.out_wr_en, 1);
    check("auipc_taken", bus.out_branch_taken, 0);
    @(negedge clk);
    check("drain_valid", bus.out_valid, 0);
    check("drain_hold_result", bus.out_result, 32'h0002_1000);

    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 32'h0, 32'd10, 32'd20, 32'h0, 5'd1, 0, 0);
    @(posedge clk);
    @(negedge clk);
    drive(2'b01, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0, 32'd1, 5'd1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      check("bp_in_ready", bus.in_ready, 0);
      check("bp_valid", bus.out_valid, 1);
      check("bp_result", bus.out_result, 32'd30);
      check("bp_rd", bus.out_rd, 1);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      check("stream_valid", bus.out_valid, 1);
      check("stream_result", bus.out_result, 32'(101 * (i - 1) + 1));
      check("stream_rd", bus.out_rd, 64'(i));
      drive(2'b01, 3'b000, 1'b0, 32'h0, 32'(i * 100), 32'h0, 32'(i + 1), 5'(i + 1), 0, 0);
    end
    @(negedge clk);
    check("stream_last_result", bus.out_result, 32'd910);
    check("stream_last_rd", bus.out_rd, 10);
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("stream_end_valid", bus.out_valid, 0);

    bus.out_ready = 1'b0;
    drive(2'b00, 3'b000, 1'b0, 32'h0, 32'd5, 32'd6, 32'h0, 5'd2, 0, 0);
    step_release();
    check("pre_rst_valid", bus.out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus.out_valid, 0);
    check("async_rst_result", bus.out_result, 0);
    check("async_rst_in_ready", bus.in_ready, 1);
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    drive(2'b00, 3'b000, 1'b0, 32'h0, 32'd3, 32'd4, 32'h0, 5'd6, 0, 0);
    step_release();
    check("post_rst_result", bus.out_result, 7);
    check("post_rst_valid", bus.out_valid, 1);

`ifdef ALU_ISSUE_FWD_EN
    fwd_exp = 32'd7;
`else
    fwd_exp = 32'd0;
`endif
    drive(2'b01, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0, 32'd7, 5'd3, 5'd0, 5'd0);
    step_release();
    check("fwd_addi_result", bus.out_result, 7);
    drive(2'b00, 3'b000, 1'b0, 32'h0, 32'd0, 32'd0, 32'h0, 5'd4, 5'd3, 5'd3);
    #1;
    check("fwd_alu_a", alu_in_a, fwd_exp);
    check("fwd_alu_b", alu_in_b, fwd_exp);
    step_release();
    check("fwd_add_result", bus.out_result, fwd_exp + fwd_exp);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
